// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch unit and its output buffer.
package fetch_pkg;

  localparam int PC_STEP_DEF   = 4;
  localparam int MEM_DEPTH_DEF = 32;

  // Buffer entry fields are sized for the widest supported PC/instruction.
  localparam int ENTRY_ADDR_W = 32;
  localparam int ENTRY_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_t;

  typedef struct packed {
    logic [ENTRY_ADDR_W-1:0] pc;
    logic [ENTRY_DATA_W-1:0] inst;
  } entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry synchronous FIFO of {pc, inst}. The head is a flop, so the outputs
// carry no combinational path from the write data.
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] din_pc,
  input  logic [DATA_W-1:0] din_inst,
  output logic [1:0]        count,
  output logic [ADDR_W-1:0] head_pc,
  output logic [DATA_W-1:0] head_inst
);

  entry_t slot0;
  entry_t slot1;
  entry_t din;
  logic   pop_ok;
  logic   wr_ok;
  logic   wr_to_head;
  logic [1:0] count_nxt;

  always_comb begin
    din.pc   = ENTRY_ADDR_W'(din_pc);
    din.inst = ENTRY_DATA_W'(din_inst);
  end

  assign pop_ok     = pop & (count != 2'd0);
  assign wr_ok      = push & ((count != 2'd2) | pop_ok);
  // After a pop the surviving entry shifts into slot0, so the write lands one lower.
  assign wr_to_head = (count == 2'd0) | ((count == 2'd1) & pop_ok);

  always_comb begin
    count_nxt = count;
    if (wr_ok && !pop_ok)
      count_nxt = count + 2'd1;
    else if (pop_ok && !wr_ok)
      count_nxt = count - 2'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= 2'd0;
      // NOTE: the two data slots are reset (unlike a RAM) so out_* read zero after reset.
      slot0 <= '0;
      slot1 <= '0;
    end else if (flush) begin
      count <= 2'd0;
    end else begin
      count <= count_nxt;
      if (pop_ok)
        slot0 <= slot1;
      // NOTE: non-blocking assignments; a later write to slot0 in this block overrides the shift.
      if (wr_ok) begin
        if (wr_to_head)
          slot0 <= din;
        else
          slot1 <= din;
      end
    end
  end

  assign head_pc   = ADDR_W'(slot0.pc);
  assign head_inst = DATA_W'(slot0.inst);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, addresses the combinational instruction memory
// and hands {pc, inst} to decode through a 2-entry valid/ready buffer.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int PC_STEP   = PC_STEP_DEF,
  parameter int MEM_DEPTH = MEM_DEPTH_DEF,
  parameter int RESET_PC  = 0
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] inst_addr,
  input  logic [DATA_W-1:0] inst_data,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_inst,
  output logic [ADDR_W-1:0] out_pc,
  output logic              stalled
);

  // MEM_DEPTH is a power of two, so modulo reduces to a mask.
  localparam logic [ADDR_W-1:0] PC_MASK  = ADDR_W'(MEM_DEPTH - 1);
  localparam logic [ADDR_W-1:0] PC_INIT  = ADDR_W'(RESET_PC);
  localparam logic [ADDR_W-1:0] PC_DELTA = ADDR_W'(PC_STEP);

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_inc;
  logic [1:0]        count;
  logic [1:0]        count_nxt;
  logic              pop;
  logic              push;

  assign pop    = out_valid & out_ready;
  assign push   = ((count != 2'd2) | pop) & ~redirect_valid & (state != IDLE);
  assign pc_inc = (pc + PC_DELTA) & PC_MASK;

  always_comb begin
    count_nxt = count;
    if (push && !pop)
      count_nxt = count + 2'd1;
    else if (pop && !push)
      count_nxt = count - 2'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc    <= PC_INIT;
      state <= IDLE;
    end else if (redirect_valid) begin
      pc    <= redirect_pc & PC_MASK;
      state <= FETCH;
    end else begin
      if (push)
        pc <= pc_inc;
      case (state)
        IDLE:    state <= FETCH;
        default: state <= (count_nxt == 2'd2) ? HOLD : FETCH;
      endcase
    end
  end

  fetch_buffer #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_buffer (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (push),
    .pop       (pop),
    .din_pc    (pc),
    .din_inst  (inst_data),
    .count     (count),
    .head_pc   (out_pc),
    .head_inst (out_inst)
  );

  assign inst_addr = pc;
  assign out_valid = (count != 2'd0);
  assign stalled   = (count == 2'd2) & ~pop & ~redirect_valid;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit against a small instruction memory model.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] inst_addr;
  logic [31:0] inst_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic        stalled;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  always #5 clk = ~clk;

  // Memory model: 0-3 -> 0, 4-7 -> 1, 8-11 -> 2, 12-15 -> 3, everything else -> 0.
  always_comb begin
    inst_data = 32'd0;
    if (inst_addr >= 32'd4 && inst_addr <= 32'd7)   inst_data = 32'd1;
    if (inst_addr >= 32'd8 && inst_addr <= 32'd11)  inst_data = 32'd2;
    if (inst_addr >= 32'd12 && inst_addr <= 32'd15) inst_data = 32'd3;
  end

  fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .inst_addr      (inst_addr),
    .inst_data      (inst_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_inst       (out_inst),
    .out_pc         (out_pc),
    .stalled        (stalled)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; out_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
    tick(); tick();
    chk_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_valid got %0b want 0", out_valid); else pass_cnt++;
    chk_cnt++; if (out_inst !== 32'd0) $display("FAIL reset_inst got %0d want 0", out_inst); else pass_cnt++;
    chk_cnt++; if (out_pc !== 32'd0) $display("FAIL reset_pc got %0d want 0", out_pc); else pass_cnt++;
    chk_cnt++; if (stalled !== 1'b0) $display("FAIL reset_stalled got %0b want 0", stalled); else pass_cnt++;
    chk_cnt++; if (inst_addr !== 32'd0) $display("FAIL reset_addr got %0d want 0", inst_addr); else pass_cnt++;
    rst = 1'b0;
    tick();  // IDLE edge: nothing pushed yet
    chk_cnt++; if (out_valid !== 1'b0) $display("FAIL idle_valid got %0b want 0", out_valid); else pass_cnt++;
    chk_cnt++; if (inst_addr !== 32'd0) $display("FAIL idle_addr got %0d want 0", inst_addr); else pass_cnt++;
  endtask

  task automatic test_free_run();
    logic [31:0] exp_pc   [5] = '{32'd0, 32'd4, 32'd8, 32'd12, 32'd16};
    logic [31:0] exp_inst [5] = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd0};
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_cnt++; if (out_valid !== 1'b1) $display("FAIL run_valid[%0d] got %0b want 1", i, out_valid); else pass_cnt++;
      chk_cnt++; if (out_pc !== exp_pc[i]) $display("FAIL run_pc[%0d] got %0d want %0d", i, out_pc, exp_pc[i]); else pass_cnt++;
      chk_cnt++; if (out_inst !== exp_inst[i]) $display("FAIL run_inst[%0d] got %0d want %0d", i, out_inst, exp_inst[i]); else pass_cnt++;
      chk_cnt++; if (inst_addr !== exp_pc[i] + 32'd4) $display("FAIL run_addr[%0d] got %0d want %0d", i, inst_addr, exp_pc[i] + 32'd4); else pass_cnt++;
    end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_pc [6] = '{32'd20, 32'd24, 32'd28, 32'd0, 32'd4, 32'd8};
    for (int i = 0; i < 6; i++) begin
      tick();
      chk_cnt++; if (out_valid !== 1'b1) $display("FAIL wrap_valid[%0d] got %0b want 1", i, out_valid); else pass_cnt++;
      chk_cnt++; if (out_pc !== exp_pc[i]) $display("FAIL wrap_pc[%0d] got %0d want %0d", i, out_pc, exp_pc[i]); else pass_cnt++;
    end
    chk_cnt++; if (inst_addr !== 32'd12) $display("FAIL wrap_addr got %0d want 12", inst_addr); else pass_cnt++;
  endtask

  task automatic test_back_pressure();
    logic [31:0] exp_pc   [2] = '{32'd12, 32'd16};
    logic [31:0] exp_inst [2] = '{32'd3, 32'd0};
    out_ready = 1'b0;
    #1;
    chk_cnt++; if (stalled !== 1'b0) $display("FAIL bp_stall_one got %0b want 0", stalled); else pass_cnt++;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_cnt++; if (stalled !== 1'b1) $display("FAIL bp_stall[%0d] got %0b want 1", i, stalled); else pass_cnt++;
      chk_cnt++; if (out_pc !== 32'd8) $display("FAIL bp_pc[%0d] got %0d want 8", i, out_pc); else pass_cnt++;
      chk_cnt++; if (out_inst !== 32'd2) $display("FAIL bp_inst[%0d] got %0d want 2", i, out_inst); else pass_cnt++;
      chk_cnt++; if (inst_addr !== 32'd16) $display("FAIL bp_addr[%0d] got %0d want 16", i, inst_addr); else pass_cnt++;
    end
    out_ready = 1'b1;
    #1;
    chk_cnt++; if (stalled !== 1'b0) $display("FAIL bp_release_stall got %0b want 0", stalled); else pass_cnt++;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk_cnt++; if (out_pc !== exp_pc[i]) $display("FAIL bp_drain_pc[%0d] got %0d want %0d", i, out_pc, exp_pc[i]); else pass_cnt++;
      chk_cnt++; if (out_inst !== exp_inst[i]) $display("FAIL bp_drain_inst[%0d] got %0d want %0d", i, out_inst, exp_inst[i]); else pass_cnt++;
    end
  endtask

  task automatic test_redirect_full();
    out_ready = 1'b0;
    #1;
    chk_cnt++; if (stalled !== 1'b1) $display("FAIL rdf_stall_pre got %0b want 1", stalled); else pass_cnt++;
    redirect_valid = 1'b1; redirect_pc = 32'd12;
    #1;
    chk_cnt++; if (stalled !== 1'b0) $display("FAIL rdf_stall_redirect got %0b want 0", stalled); else pass_cnt++;
    tick();
    redirect_valid = 1'b0;
    chk_cnt++; if (out_valid !== 1'b0) $display("FAIL rdf_valid got %0b want 0", out_valid); else pass_cnt++;
    chk_cnt++; if (inst_addr !== 32'd12) $display("FAIL rdf_addr got %0d want 12", inst_addr); else pass_cnt++;
    tick();
    chk_cnt++; if (out_valid !== 1'b1) $display("FAIL rdf_valid2 got %0b want 1", out_valid); else pass_cnt++;
    chk_cnt++; if (out_pc !== 32'd12) $display("FAIL rdf_pc got %0d want 12", out_pc); else pass_cnt++;
    chk_cnt++; if (out_inst !== 32'd3) $display("FAIL rdf_inst got %0d want 3", out_inst); else pass_cnt++;
  endtask

  task automatic test_redirect_range();
    out_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h44;
    tick();
    redirect_valid = 1'b0;
    chk_cnt++; if (inst_addr !== 32'd4) $display("FAIL rdr_addr got %0d want 4", inst_addr); else pass_cnt++;
    chk_cnt++; if (out_valid !== 1'b0) $display("FAIL rdr_valid got %0b want 0", out_valid); else pass_cnt++;
    tick();
    chk_cnt++; if (out_pc !== 32'd4) $display("FAIL rdr_pc got %0d want 4", out_pc); else pass_cnt++;
    chk_cnt++; if (out_inst !== 32'd1) $display("FAIL rdr_inst got %0d want 1", out_inst); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    tick();
    chk_cnt++; if (stalled !== 1'b1) $display("FAIL rsm_full got %0b want 1", stalled); else pass_cnt++;
    rst = 1'b1;
    tick();
    rst = 1'b0; out_ready = 1'b1;
    chk_cnt++; if (out_valid !== 1'b0) $display("FAIL rsm_valid got %0b want 0", out_valid); else pass_cnt++;
    chk_cnt++; if (inst_addr !== 32'd0) $display("FAIL rsm_addr got %0d want 0", inst_addr); else pass_cnt++;
    chk_cnt++; if (out_pc !== 32'd0) $display("FAIL rsm_pc got %0d want 0", out_pc); else pass_cnt++;
    chk_cnt++; if (stalled !== 1'b0) $display("FAIL rsm_stalled got %0b want 0", stalled); else pass_cnt++;
    tick();
    chk_cnt++; if (out_valid !== 1'b0) $display("FAIL rsm_idle_valid got %0b want 0", out_valid); else pass_cnt++;
    tick();
    chk_cnt++; if (out_valid !== 1'b1) $display("FAIL rsm_restart_valid got %0b want 1", out_valid); else pass_cnt++;
    chk_cnt++; if (out_pc !== 32'd0) $display("FAIL rsm_restart_pc got %0d want 0", out_pc); else pass_cnt++;
    chk_cnt++; if (out_inst !== 32'd0) $display("FAIL rsm_restart_inst got %0d want 0", out_inst); else pass_cnt++;
    tick();
    chk_cnt++; if (out_pc !== 32'd4) $display("FAIL rsm_next_pc got %0d want 4", out_pc); else pass_cnt++;
    chk_cnt++; if (out_inst !== 32'd1) $display("FAIL rsm_next_inst got %0d want 1", out_inst); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_wrap();
    test_back_pressure();
    test_redirect_full();
    test_redirect_range();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Fetch-side initiator for the combinational instruction memory.
- Owns the program counter and drives the instruction address each cycle.
- Captures the returned instruction word together with its PC into a 2-entry buffer and presents it to decode over a valid/ready handshake.
- Supports stalls (back-pressure from decode) and PC redirects (branch/jump), and wraps within the memory's address range.

Parameters:
- ADDR_W, 32, width of PC and instruction address.
- DATA_W, 32, instruction word width.
- PC_STEP, 4, PC increment per fetched instruction (byte addressing; memory replicates each word across 4 consecutive addresses).
- MEM_DEPTH, 32, addressable memory locations; power of 2; PC is kept modulo MEM_DEPTH.
- RESET_PC, 0, PC value loaded on reset; must be < MEM_DEPTH.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- inst_addr  out  ADDR_W  address to instruction memory, equal to the PC register (combinational from PC).
- inst_data  in  DATA_W  instruction word returned combinationally by memory in the same cycle.
- redirect_valid  in  1  load a new PC this cycle.
- redirect_pc  in  ADDR_W  redirect target; the low log2(MEM_DEPTH) bits are used and the upper bits are ignored.
- out_valid  out  1  buffer head holds a valid instruction.
- out_ready  in  1  decode accepts the head this cycle.
- out_inst  out  DATA_W  instruction at the buffer head.
- out_pc  out  ADDR_W  PC of out_inst.
- stalled  out  1  buffer full and no pop this cycle, so the PC is held.

Behaviour:
Reset
- While rst=1 at a clock edge: pc<=RESET_PC, buffer count<=0, state<=IDLE.
- Outputs during and after reset: out_valid=0, out_inst=0, out_pc=0, stalled=0, inst_addr=RESET_PC.
- Reset mid-operation discards buffered entries with no partial output.

State machine (2 bits)
- IDLE: the first cycle after reset. No push. Go to FETCH.
- FETCH: normal operation (push/pop rules below).
- HOLD: buffer full. Push only when a pop occurs in the same cycle, otherwise hold. Go back to FETCH when count<2 after the update.
- A redirect in any state goes to FETCH.

Push/pop (FETCH/HOLD)
- pop = out_valid & out_ready.
- push = (count<2 | pop) & ~redirect_valid & state!=IDLE.
- On push: enqueue {pc, inst_data}, then pc <= (pc+PC_STEP) mod MEM_DEPTH. Example: with default parameters, 28 goes to 0.
- If not push: pc holds.
- Simultaneous push and pop at count=2: count stays 2 and the order is preserved (FIFO).
- stalled = (count==2) & ~pop & ~redirect_valid.

Redirect
- When redirect_valid=1 at an edge: flush the buffer (count<=0), pc <= redirect_pc mod MEM_DEPTH, no push that cycle.
- Redirect has priority over push and pop. A pop in the same cycle is still considered accepted by decode, but the entry is discarded.
- Next cycle: out_valid=0 and inst_addr=new pc.
- The cycle after that: out_valid=1 with out_pc=the target.

Latency
- An instruction pushed at edge N is visible on out_* in the cycle after edge N (1-cycle fetch-to-decode latency).
- The buffer head is registered: out_inst and out_pc are driven from flops, with no combinational path from inst_data.

Empty/full
- count=0 gives out_valid=0.
- out_valid depends only on count, never on out_ready.
- Data on out_* is stable while out_valid=1 and out_ready=0.

Decomposition:
- Shared package fetch_pkg holds:
  - state enum (IDLE, FETCH, HOLD);
  - entry struct {pc, inst};
  - constants PC_STEP_DEF=4 and MEM_DEPTH_DEF=32.
- One natural sub-module: fetch_buffer, a 2-entry synchronous FIFO with push, pop, flush, count, and head outputs. fetch_unit instantiates it and holds the PC and the FSM.

Test Plan:
- Bench memory model: addresses 0–3 return 0, 4–7 return 1, 8–11 return 2, 12–15 return 3, 16–31 return 0.
- Reset then free-run with out_ready=1: outputs begin the cycle after the first push. Expect (pc,inst) = (0,0),(4,1),(8,2),(12,3),(16,0), one per cycle, with inst_addr stepping by 4.
- Wrap: free-run past pc=28. Expect out_pc 24,28,0,4 with no gap in out_valid.
- Back-pressure: drop out_ready for 5 cycles at pc=8. Expect stalled=1 after 2 entries buffered and out_pc held at 8 with stable out_inst=2. On release, expect 8,12,16 in order with no loss or duplicate.
- Redirect while full: assert redirect_valid with redirect_pc=12 while count=2 and out_ready=0. Next cycle expect out_valid=0 and inst_addr=12. The cycle after, expect out_pc=12, out_inst=3.
- Redirect out of range: redirect_pc=0x44. Expect pc=4 and out_inst=1.
- Reset mid-stream: assert rst for 1 cycle while count=2. Expect out_valid=0 and inst_addr=RESET_PC. Then the sequence restarts at (0,0).
